// File: rtl/data_bridge_responder.sv
// Responder side of the CPU data bridge: latches one load/store, routes it to one of two
// device windows, and returns data or a bus error (unmapped/timeout). Also syncs ext_int.
module data_bridge_responder #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_0000,
  parameter logic [31:0] DEV0_MASK = 32'hFFFF_C000,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_MASK = 32'hFFFF_FFF0,
  parameter int          TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] dev_addr,
  output logic        dev_we,
  output logic [3:0]  dev_be,
  output logic [31:0] dev_wdata,
  output logic        dev0_req,
  output logic        dev1_req,
  input  logic        dev0_ack,
  input  logic [31:0] dev0_rdata,
  input  logic        dev1_ack,
  input  logic [31:0] dev1_rdata,
  input  logic [5:0]  ext_int,
  output logic [5:0]  hw_int
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;     // 0 = device 0, 1 = device 1
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        ld;
  logic        hit0, hit1, ack_sel;
  logic [31:0] rd_sel;
  logic [1:0][5:0] int_sync;

  assign hit0    = (cpu_addr & DEV0_MASK) == DEV0_BASE;
  assign hit1    = (cpu_addr & DEV1_MASK) == DEV1_BASE;
  assign ack_sel = sel_q ? dev1_ack : dev0_ack;
  assign rd_sel  = sel_q ? dev1_rdata : dev0_rdata;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ld      = 1'b0;
    case (state_q)
      IDLE: if (cpu_req) begin
        ld    = 1'b1;
        cnt_d = '0;
        if (hit0) begin
          sel_d   = 1'b0;
          state_d = ACCESS;
        end else if (hit1) begin
          sel_d   = 1'b1;
          state_d = ACCESS;
        end else begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end
      end
      ACCESS: begin
        // ack takes precedence over an expiring counter in the same cycle
        if (ack_sel) begin
          err_d   = 1'b0;
          rdata_d = dev_we ? '0 : rd_sel;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      dev_addr  <= '0;
      dev_we    <= 1'b0;
      dev_be    <= '0;
      dev_wdata <= '0;
      int_sync  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      int_sync <= {int_sync[0], ext_int};
      if (ld) begin
        dev_addr  <= cpu_addr;
        dev_we    <= cpu_we;
        dev_be    <= cpu_be;
        dev_wdata <= cpu_wdata;
      end
    end
  end

  assign dev0_req  = (state_q == ACCESS) && !sel_q;
  assign dev1_req  = (state_q == ACCESS) && sel_q;
  assign cpu_ready = (state_q == RESP);
  assign cpu_err   = cpu_ready && err_q;
  assign cpu_rdata = cpu_ready ? rdata_q : '0;
  assign hw_int    = int_sync[1];

endmodule

// File: tb/tb_data_bridge_responder.sv
// Directed bench for data_bridge_responder: dev0/dev1 accesses, unmapped error, timeout,
// mid-access reset and interrupt synchronizer.
module tb_data_bridge_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        cpu_ready, cpu_err;
  logic [31:0] dev_addr, dev_wdata;
  logic        dev_we;
  logic [3:0]  dev_be;
  logic        dev0_req, dev1_req, dev0_ack, dev1_ack;
  logic [31:0] dev0_rdata, dev1_rdata;
  logic [5:0]  ext_int, hw_int;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  data_bridge_responder dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dev_addr(dev_addr), .dev_we(dev_we), .dev_be(dev_be), .dev_wdata(dev_wdata),
    .dev0_req(dev0_req), .dev1_req(dev1_req),
    .dev0_ack(dev0_ack), .dev0_rdata(dev0_rdata),
    .dev1_ack(dev1_ack), .dev1_rdata(dev1_rdata),
    .ext_int(ext_int), .hw_int(hw_int)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int  hi;
    bit  done, any_rdy;
    logic err_s;
    logic [31:0] rd_s;

    rst = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    dev0_ack = 0; dev1_ack = 0; dev0_rdata = '0; dev1_rdata = '0; ext_int = '0;
    #2;
    chk("rst_ctl", {29'd0, cpu_ready, cpu_err, dev0_req | dev1_req}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_dev", {dev_addr ^ dev_wdata, dev_we, dev_be, hw_int} != '0, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // dev0 load, ack one cycle after req
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010;
    cyc();
    chk("t1_req", {30'd0, dev0_req, dev1_req}, 32'd2);
    chk("t1_addr", dev_addr, 32'h0000_0010);
    chk("t1_nrdy", cpu_ready, 0);
    dev0_ack = 1; dev0_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("t1_rdy", {30'd0, cpu_ready, cpu_err}, 32'd2);
    chk("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t1_req_drop", dev0_req, 0);
    dev0_ack = 0; cpu_req = 0;
    cyc();
    chk("t1_pulse", cpu_ready, 0);

    // dev1 store, three wait cycles; stray dev0_ack must be ignored
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_7F04; cpu_be = 4'b0011; cpu_wdata = 32'h1234;
    hi = 0; any_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (dev1_req && !dev0_req) hi++;
      if (cpu_ready) any_rdy = 1;
      dev0_ack = (i == 0);
      if (i == 3) begin dev1_ack = 1; dev1_rdata = 32'h0000_FFFF; end
    end
    chk("t2_req_cycles", hi, 4);
    chk("t2_early_rdy", any_rdy, 0);
    cyc();
    chk("t2_rdy", {30'd0, cpu_ready, cpu_err}, 32'd2);
    chk("t2_rdata", cpu_rdata, 32'd0);
    chk("t2_wdata", dev_wdata, 32'h1234);
    chk("t2_be_we", {27'd0, dev_we, dev_be}, 32'h13);
    dev1_ack = 0; cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_wdata = 0;
    cyc();

    // unmapped load; cpu_req held through RESP is not a second request
    cpu_req = 1; cpu_addr = 32'h8000_0000;
    cyc();
    chk("t3_rdy_err", {29'd0, cpu_ready, cpu_err, dev0_req | dev1_req}, 32'd6);
    chk("t3_rdata", cpu_rdata, 32'd0);
    cyc();
    chk("t3_no_rerun", {30'd0, cpu_ready, dev0_req | dev1_req}, 32'd0);
    cpu_req = 0;
    cyc(); cyc();

    // dev0 never acks: timeout after 15 cycles, late ack ignored
    cpu_req = 1; cpu_addr = 32'h0000_0020;
    hi = 0; done = 0; err_s = 0; rd_s = '1;
    for (int c = 0; c < 40 && !done; c++) begin
      cyc();
      if (dev0_req) hi++;
      if (cpu_ready) begin done = 1; err_s = cpu_err; rd_s = cpu_rdata; end
    end
    chk("t4_done", done, 1);
    chk("t4_req_cycles", hi, 15);
    chk("t4_err", err_s, 1);
    chk("t4_rdata", rd_s, 32'd0);
    cpu_req = 0;
    cyc();
    dev0_ack = 1; any_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (cpu_ready || dev0_req) any_rdy = 1;
    end
    chk("t4_late_ack", any_rdy, 0);
    dev0_ack = 0;

    // reset while dev1_req is high
    cpu_req = 1; cpu_addr = 32'h0000_7F08;
    cyc();
    chk("t5_pre", dev1_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async", {28'd0, dev0_req, dev1_req, cpu_ready, cpu_err}, 32'd0);
    chk("t5_dev_addr", dev_addr, 32'd0);
    cpu_req = 0; dev1_ack = 1;
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("t5_ack_ignored", {30'd0, cpu_ready, dev1_req}, 32'd0);
    dev1_ack = 0;
    cpu_req = 1; cpu_addr = 32'h0000_0100;
    cyc();
    chk("t5_dev0_req", dev0_req, 1);
    dev0_ack = 1; dev0_rdata = 32'hCAFE_0001;
    cyc();
    chk("t5_rdy", {30'd0, cpu_ready, cpu_err}, 32'd2);
    chk("t5_rdata", cpu_rdata, 32'hCAFE_0001);
    dev0_ack = 0; cpu_req = 0;
    cyc();

    // interrupt synchronizer: two edges of latency, level held
    ext_int = 6'b100001;
    cyc();
    chk("t6_one_edge", hw_int, 6'd0);
    cyc();
    chk("t6_two_edges", hw_int, 6'b100001);
    cyc(); cyc();
    chk("t6_held", hw_int, 6'b100001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_bridge_responder.md
Name: data_bridge_responder

Overview:
- Responder end of the CPU data-bridge protocol. The pipeline's EX/MEM stages issue load/store requests; this block answers them.
- Latches one request, decodes the address to one of two device windows, and drives a request/acknowledge handshake to the selected device.
- Returns read data or a bus error to the CPU, with a timeout on devices that never acknowledge.
- Also synchronizes external interrupt lines for CP0.
- One request is outstanding at a time; requests are never pipelined.

Parameters:
- DEV0_BASE, 32'h0000_0000: device 0 window base (RAM).
- DEV0_MASK, 32'hFFFF_C000: device 0 window mask; hit when (addr & MASK) == BASE.
- DEV1_BASE, 32'h0000_7F00: device 1 window base (timer/IO).
- DEV1_MASK, 32'hFFFF_FFF0: device 1 window mask.
- TIMEOUT, 15: maximum cycles in ACCESS before an error response; range 1..255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- cpu_req  in  1  CPU request valid; held high until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_be  in  4  byte enables for stores.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  qualifies cpu_ready: unmapped address or timeout.
- dev_addr  out  32  latched address.
- dev_we  out  1  latched write enable.
- dev_be  out  4  latched byte enables.
- dev_wdata  out  32  latched store data.
- dev0_req  out  1  device 0 access strobe.
- dev1_req  out  1  device 1 access strobe.
- dev0_ack  in  1  device 0 done; dev0_rdata valid in the same cycle.
- dev0_rdata  in  32  device 0 read data.
- dev1_ack  in  1  device 1 done.
- dev1_rdata  in  32  device 1 read data.
- ext_int  in  6  asynchronous external interrupt lines.
- hw_int  out  6  synchronized interrupts to CP0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State IDLE.
  - All outputs 0: cpu_rdata, cpu_ready, cpu_err, dev_*, dev0_req, dev1_req, hw_int.
  - Timeout counter and synchronizer flops cleared.
  - Reset mid-transaction abandons the access; a device ack arriving after reset is ignored.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - cpu_req is sampled only in IDLE.
  - On cpu_req = 1, latch cpu_addr, cpu_we, cpu_be and cpu_wdata into dev_*, then decode.
  - DEV0 hit → ACCESS with dev0_req = 1.
  - Else DEV1 hit → ACCESS with dev1_req = 1.
  - Neither hit → RESP with err = 1 and rdata = 0.
  - DEV0 has priority if the two windows overlap.
- ACCESS:
  - The selected devX_req stays high.
  - The counter increments each cycle from 0.
  - On selected devX_ack = 1: register devX_rdata (stores register 0), err = 0, go to RESP, drop req.
  - The ack of the non-selected device is ignored.
  - If the counter reaches TIMEOUT-1 with no ack: go to RESP, err = 1, rdata = 0.
  - Ack and timeout in the same cycle: the ack wins.
- RESP:
  - cpu_ready = 1 and cpu_err/cpu_rdata driven for exactly one cycle, then IDLE.
  - cpu_req high during RESP is not a new request.
  - A new request is accepted no earlier than the cycle after RESP.
- Latency:
  - Request sampled at edge N, ack in cycle N+1 → cpu_ready high in cycle N+2 (minimum 2 cycles from req to ready).
  - Unmapped address: ready in cycle N+1.
- Device acks outside ACCESS are ignored. dev_* hold their latched values until the next accepted request.
- hw_int: 2-flop synchronizer per bit, so an ext_int change appears on hw_int 2 edges later. No edge detection; level-passed.

Test Plan:
- Load at 0x0000_0010; dev0_ack one cycle after dev0_req with dev0_rdata = 0xDEADBEEF → dev0_req is a single cycle; cpu_ready pulse with cpu_rdata = 0xDEADBEEF and cpu_err = 0, 2 cycles after req.
- Store at 0x0000_7F04, be = 4'b0011, wdata = 0x1234; dev1 acks after 3 waits → dev1_req high 4 cycles; dev_wdata = 0x1234, dev_be = 3; cpu_ready with rdata = 0, err = 0.
- Load at 0x8000_0000 (unmapped) → no dev req; cpu_ready and cpu_err = 1 the next cycle, rdata = 0.
- Load to dev0, never acked, TIMEOUT = 15 → dev0_req high exactly 15 cycles, then cpu_ready with err = 1; a late dev0_ack afterwards produces no response.
- Assert rst low while dev1_req is high → dev1_req and all outputs 0 immediately (before the next edge); after release, a new load to dev0 completes normally.
- ext_int = 6'b100001 → hw_int = 6'b100001 after 2 edges; the value persists while ext_int is held.
